serial_input_loader: RTL
========================

// Module: serial_input_loader
// PURPOSE
//   Front-end loader of the deconvolution kernel estimator. Deserialises the LSB-first serial_in
//   stream into DATA_WIDTH-bit words. Words go to the phase/frequency-vector SRAM or the TF-coefficient
//   SRAM with auto-incrementing addresses, or into the ADC-bypass register. Sits between the chip pins
//   and the SRAM write ports / frequency-evaluation core.
// PARAMETERS
//   DATA_WIDTH   16    word width, bits shifted per word
//   ADDR_WIDTH   12    SRAM word-address width
//   PHASE_DEPTH  1275  valid words in phase SRAM (FREQ_VEC_LENGTH)
//   COEFF_DEPTH  4096  valid words in coefficient SRAM (2*DEPTH)
// PORTS
//   clk               in   1           system clock, all logic on rising edge
//   rst               in   1           synchronous, active-high reset
//   load_en           in   1           serial load window; one bit per cycle while high
//   serial_in         in   1           serial data, LSB of each word first
//   sram_select       in   2           00 phase SRAM, 01 coeff SRAM, 1x output SRAMs (not loadable)
//   adc_bypass_en     in   1           route words to ADC-bypass register; overrides sram_select
//   phase_wr_en       out  1           1-cycle write strobe, phase SRAM
//   coeff_wr_en       out  1           1-cycle write strobe, coefficient SRAM
//   wr_addr           out  ADDR_WIDTH  word address for the active strobe
//   wr_data           out  DATA_WIDTH  assembled word for the active strobe
//   adc_bypass_data   out  DATA_WIDTH  last word captured while in bypass mode
//   adc_bypass_valid  out  1           sticky; set on first bypass capture
//   load_busy         out  1           high while in LOAD state
//   load_overflow     out  1           sticky; a word was dropped beyond depth or to a read-only target
// BEHAVIOUR
//   Reset: every output is 0. FSM is in IDLE. Bit counter, shift register, address and target are cleared.
//   FSM: IDLE -> LOAD when load_en=1. LOAD -> IDLE when load_en=0.
//   Session start (IDLE with load_en=1): latch target from {adc_bypass_en, sram_select}. Clear the address
//     counter and load_overflow. The first bit is shifted in the same cycle.
//   Mid-session changes to sram_select and adc_bypass_en are ignored.
//   Shift: each cycle with load_en=1, sr <= {serial_in, sr[W-1:1]} and bit_cnt increments.
//     When bit_cnt = DATA_WIDTH-1, the word is complete, bit_cnt wraps to 0 and the word is committed.
//   Commit timing: the strobe, wr_addr and wr_data are registered. They assert the cycle after the final
//     bit, even if load_en has already dropped. The strobe is high for exactly one cycle, with wr_addr
//     equal to the pre-increment count. Back-to-back words give one strobe every DATA_WIDTH cycles.
//   Target rules:
//     bypass: adc_bypass_data <= word and adc_bypass_valid <= 1. No SRAM strobe, address unchanged.
//     phase/coeff: strobe only while addr < PHASE_DEPTH or < COEFF_DEPTH respectively. Otherwise the word
//       is dropped and load_overflow is set.
//     sram_select=1x without bypass: word dropped, load_overflow set.
//   load_en low mid-word: the partial word is discarded, bit_cnt=0 and sr=0. The address is held until
//     the next session start.
//   A new session starting the cycle a prior commit is pending: the pending strobe completes with the
//     old target and address. The new session then starts at address 0.
//   rst mid-session: the pending strobe is cancelled and nothing is written the following cycle.
//   The address counter saturates at 2^ADDR_WIDTH-1 and never wraps.
// STRUCTURE
//   Shared package deconv_pkg: SRAM_SEL_PHASE=2'b00, SRAM_SEL_COEFF=2'b01, SRAM_SEL_MAG=2'b10,
//     SRAM_SEL_PHASE_OUT=2'b11, loader state encoding, default DATA_WIDTH/ADDR_WIDTH.
//   Sub-module serial_word_deserializer: shift register, bit counter, word_done pulse, clear input.
//   The parent holds the FSM, target latch, address counter, commit register and flags.
// TESTING
//   1. Phase load: 1275 words, word i = 16'h1000+i, sel=00 -> 1275 phase_wr_en strobes at addr 0..1274
//      with matching data; coeff_wr_en never high; load_overflow=0.
//   2. Coefficient overrun: 4097 words, sel=01 -> strobes at addr 0..4095, 4097th word dropped,
//      load_overflow=1; a new session clears it.
//   3. ADC bypass: 16'h0A4F with adc_bypass_en=1, load_en dropped right after bit 15 ->
//      adc_bypass_data=16'h0A4F and valid=1 one cycle later; no SRAM strobe.
//   4. Partial word: load_en low after 9 bits, then a full session sel=00 word 16'hBEEF ->
//      single strobe at addr 0 with data 16'hBEEF.
//   5. sel=10 load of 3 words -> no strobes, load_overflow=1; then rst asserted during bit 15 of a
//      phase word -> no strobe next cycle, all outputs 0.

Source files
------------

// File: rtl/deconv_pkg.sv
// Shared definitions for the deconvolution kernel estimator front end.
// Holds the SRAM target encodings seen on the sram_select pins, the serial
// loader state encoding and the default word/address widths.
package deconv_pkg;

    // Target encodings presented on sram_select
    localparam logic [1:0] SRAM_SEL_PHASE     = 2'b00;
    localparam logic [1:0] SRAM_SEL_COEFF     = 2'b01;
    localparam logic [1:0] SRAM_SEL_MAG       = 2'b10;
    localparam logic [1:0] SRAM_SEL_PHASE_OUT = 2'b11;

    // Default geometry of the loader
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 12;

    // Serial loader FSM states
    typedef enum logic [0:0] {
        LDR_IDLE = 1'b0,
        LDR_LOAD = 1'b1
    } loader_state_e;

endpackage : deconv_pkg

// File: rtl/serial_word_deserializer.sv
// LSB-first serial-to-parallel converter.
// Shifts one bit per cycle while shift_en is high and flags the cycle in
// which the final bit of a word arrives. The completed word is presented
// combinationally in that same cycle so the parent can register it.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   clear       discard any partial word (shift register and counter to 0)
//   shift_en    shift serial_in in this cycle
//   serial_in   serial data bit
//   word        word as it stands after this cycle's shift
//   word_done   high in the cycle the last bit of a word is shifted in
module serial_word_deserializer
    import deconv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] sr_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  word_done_s;

    // Next-word view and completion detect for the current cycle
    always_comb begin
        word_s      = {serial_in, sr_r[DATA_WIDTH-1:1]};
        word_done_s = 1'b0;
        if (shift_en && !clear && (bit_cnt_r == LAST_CNT)) begin
            word_done_s = 1'b1;
        end else begin
            word_done_s = 1'b0;
        end
    end

    // Shift register and bit counter; clear drops a partial word
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r      <= '0;
            bit_cnt_r <= '0;
        end else if (clear) begin
            sr_r      <= '0;
            bit_cnt_r <= '0;
        end else if (shift_en) begin
            sr_r <= word_s;
            if (word_done_s) begin
                bit_cnt_r <= '0;
            end else begin
                bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            sr_r      <= sr_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    assign word      = word_s;
    assign word_done = word_done_s;

endmodule : serial_word_deserializer

// File: rtl/serial_input_loader.sv
// Front-end serial loader of the deconvolution kernel estimator.
// Turns the LSB-first serial_in stream into words and routes each word to
// the phase SRAM, the coefficient SRAM (auto-incrementing address) or the
// ADC-bypass register. The target is latched at session start.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   load_en           serial load window, one bit per cycle while high
//   serial_in         serial data, LSB first
//   sram_select       00 phase, 01 coeff, 1x read-only output SRAMs
//   adc_bypass_en     route words to the ADC-bypass register
//   phase_wr_en       one-cycle phase SRAM write strobe
//   coeff_wr_en       one-cycle coefficient SRAM write strobe
//   wr_addr, wr_data  address/data accompanying the strobe
//   adc_bypass_data   last word captured in bypass mode
//   adc_bypass_valid  sticky, set on first bypass capture
//   load_busy         high while in the LOAD state
//   load_overflow     sticky per session, a word was dropped
module serial_input_loader
    import deconv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int PHASE_DEPTH = 1275,
    parameter int COEFF_DEPTH = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  serial_in,
    input  logic [1:0]            sram_select,
    input  logic                  adc_bypass_en,
    output logic                  phase_wr_en,
    output logic                  coeff_wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] adc_bypass_data,
    output logic                  adc_bypass_valid,
    output logic                  load_busy,
    output logic                  load_overflow
);

    // Depth limits need one extra bit: COEFF_DEPTH can equal 2^ADDR_WIDTH
    localparam logic [ADDR_WIDTH:0] PHASE_LIMIT = PHASE_DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] COEFF_LIMIT = COEFF_DEPTH[ADDR_WIDTH:0];

    loader_state_e         state_r;
    loader_state_e         state_nxt_s;
    logic [2:0]            target_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  addr_full_r;
    logic                  phase_wr_en_r;
    logic                  coeff_wr_en_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;
    logic [DATA_WIDTH-1:0] adc_data_r;
    logic                  adc_valid_r;
    logic                  busy_r;
    logic                  overflow_r;

    logic                  session_start_s;
    logic [2:0]            tgt_s;
    logic [ADDR_WIDTH-1:0] cur_addr_s;
    logic                  cur_full_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  word_done_s;
    logic                  phase_hit_s;
    logic                  coeff_hit_s;
    logic                  bypass_hit_s;
    logic                  drop_s;

    serial_word_deserializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .clear     (!load_en),
        .shift_en  (load_en),
        .serial_in (serial_in),
        .word      (word_s),
        .word_done (word_done_s)
    );

    // Next-state logic of the load window FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LDR_IDLE: begin
                if (load_en) begin
                    state_nxt_s = LDR_LOAD;
                end else begin
                    state_nxt_s = LDR_IDLE;
                end
            end
            LDR_LOAD: begin
                if (!load_en) begin
                    state_nxt_s = LDR_IDLE;
                end else begin
                    state_nxt_s = LDR_LOAD;
                end
            end
            default: state_nxt_s = LDR_IDLE;
        endcase
    end

    // Effective target/address: a session-start cycle already sees the new
    // target and a cleared address, later cycles use the latched copies
    always_comb begin
        session_start_s = (state_r == LDR_IDLE) && load_en;
        tgt_s           = target_r;
        cur_addr_s      = addr_r;
        cur_full_s      = addr_full_r;
        if (session_start_s) begin
            tgt_s      = {adc_bypass_en, sram_select};
            cur_addr_s = '0;
            cur_full_s = 1'b0;
        end else begin
            tgt_s      = target_r;
            cur_addr_s = addr_r;
            cur_full_s = addr_full_r;
        end
    end

    // Commit decode: where a just-completed word goes, or whether it drops
    always_comb begin
        phase_hit_s  = 1'b0;
        coeff_hit_s  = 1'b0;
        bypass_hit_s = 1'b0;
        drop_s       = 1'b0;
        if (word_done_s) begin
            if (tgt_s[2]) begin
                bypass_hit_s = 1'b1;
            end else begin
                case (tgt_s[1:0])
                    SRAM_SEL_PHASE: begin
                        if (!cur_full_s && ({1'b0, cur_addr_s} < PHASE_LIMIT)) begin
                            phase_hit_s = 1'b1;
                        end else begin
                            drop_s = 1'b1;
                        end
                    end
                    SRAM_SEL_COEFF: begin
                        if (!cur_full_s && ({1'b0, cur_addr_s} < COEFF_LIMIT)) begin
                            coeff_hit_s = 1'b1;
                        end else begin
                            drop_s = 1'b1;
                        end
                    end
                    SRAM_SEL_MAG:       drop_s = 1'b1;
                    SRAM_SEL_PHASE_OUT: drop_s = 1'b1;
                    default:            drop_s = 1'b1;
                endcase
            end
        end else begin
            drop_s = 1'b0;
        end
    end

    // State, target latch, address counter, commit register and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= LDR_IDLE;
            target_r      <= 3'b000;
            addr_r        <= '0;
            addr_full_r   <= 1'b0;
            phase_wr_en_r <= 1'b0;
            coeff_wr_en_r <= 1'b0;
            wr_addr_r     <= '0;
            wr_data_r     <= '0;
            adc_data_r    <= '0;
            adc_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            busy_r        <= (state_nxt_s == LDR_LOAD);
            phase_wr_en_r <= phase_hit_s;
            coeff_wr_en_r <= coeff_hit_s;
            if (session_start_s) begin
                target_r    <= tgt_s;
                addr_r      <= '0;
                addr_full_r <= 1'b0;
                overflow_r  <= 1'b0;
            end
            if (phase_hit_s || coeff_hit_s) begin
                wr_addr_r <= cur_addr_s;
                wr_data_r <= word_s;
                // Saturate: the last address is written once, then the
                // counter is marked exhausted instead of wrapping
                if (cur_addr_s == {ADDR_WIDTH{1'b1}}) begin
                    addr_r      <= cur_addr_s;
                    addr_full_r <= 1'b1;
                end else begin
                    addr_r <= cur_addr_s + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            if (bypass_hit_s) begin
                adc_data_r  <= word_s;
                adc_valid_r <= 1'b1;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign phase_wr_en      = phase_wr_en_r;
    assign coeff_wr_en      = coeff_wr_en_r;
    assign wr_addr          = wr_addr_r;
    assign wr_data          = wr_data_r;
    assign adc_bypass_data  = adc_data_r;
    assign adc_bypass_valid = adc_valid_r;
    assign load_busy        = busy_r;
    assign load_overflow    = overflow_r;

endmodule : serial_input_loader
